// File: rtl/control_layer_seq_if.sv
// Purpose: pixel-source / datapath strobe bundle for the per-layer control sequencer.
// Latency: none (wires only); timing is set by control_layer_seq.
// Backpressure: source must hold pixels while busy; downstream strobes never stall.
interface control_layer_seq_if #(
    parameter int CONV_LAT = 4,
    parameter int BIAS_LAT = 5
);
    logic                valid_in;
    logic                busy;
    logic                padding_valid;
    logic [15:0]         counter_col;
    logic [15:0]         counter_row;
    logic                valid_window;
    logic [CONV_LAT-1:0] valid_pipeline_conv;
    logic                valid_in_bias;
    logic [BIAS_LAT-1:0] valid_pipeline_bias;
    logic                valid_in_pool;
    logic                valid_pool_h;
    logic                valid_out;
    logic                frame_done;

    // Pixel source side: offers pixels, observes sequencer strobes.
    modport master (
        output valid_in,
        input  busy, padding_valid, counter_col, counter_row, valid_window,
               valid_pipeline_conv, valid_in_bias, valid_pipeline_bias,
               valid_in_pool, valid_pool_h, valid_out, frame_done
    );

    // Sequencer side.
    modport slave (
        input  valid_in,
        output busy, padding_valid, counter_col, counter_row, valid_window,
               valid_pipeline_conv, valid_in_bias, valid_pipeline_bias,
               valid_in_pool, valid_pool_h, valid_out, frame_done
    );
endinterface

// File: rtl/control_layer_seq.sv
// Purpose: raster tracker, window strobes, end-of-frame padding flush, conv/bias valid pipes, 2x2 pool gating.
// Latency: pixel -> valid_window 1 cycle; valid_window -> valid_out CONV_LAT+BIAS_LAT+1 cycles.
// Backpressure: busy (during flush) tells the source to hold; the strobe pipelines never stall.
module control_layer_seq #(
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 32,
    parameter int KERNEL   = 3,
    parameter int PAD      = 1,
    parameter int CONV_LAT = 4,
    parameter int BIAS_LAT = 5,
    parameter int POOL_EN  = 1
) (
    input  logic               clk,
    input  logic               rst,
    control_layer_seq_if.slave cl
);
    localparam int P  = (KERNEL - 1) / 2;
    localparam int OW = (PAD == 1) ? WIDTH  : WIDTH  - KERNEL + 1;
    localparam int OH = (PAD == 1) ? HEIGHT : HEIGHT - KERNEL + 1;
    // A 1x1 kernel has nothing to flush even in same-padding mode.
    localparam bit USE_FLUSH = (PAD == 1) && (P > 0);

    localparam logic [15:0] W_LAST     = 16'(WIDTH - 1);
    localparam logic [15:0] H_LAST     = 16'(HEIGHT - 1);
    localparam logic [15:0] P16        = 16'(P);
    localparam logic [15:0] K_LAST     = 16'(KERNEL - 1);
    localparam logic [15:0] W_MINUS_P  = 16'(WIDTH - P);
    localparam logic [15:0] FLUSH_LAST = 16'(P * WIDTH + P - 1);
    localparam logic [15:0] OW_LAST    = 16'(OW - 1);
    localparam logic [15:0] OH_LAST    = 16'(OH - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t              state;
    logic [15:0]         ic, ir, fcnt;
    logic [15:0]         oc, orow;
    logic [15:0]         ccol, crow;
    logic                frame_done;
    logic                win_vld;
    logic                out_vld;
    logic [CONV_LAT-1:0] conv_pipe;
    logic [BIAS_LAT-1:0] bias_pipe;

    logic        accept, inject, pix_evt, win_hit, last_pix;
    logic [15:0] cen_col, cen_row;

    assign accept   = (state == RUN) && cl.valid_in;
    assign inject   = (state == FLUSH);
    assign pix_evt  = accept || inject;
    assign last_pix = accept && (ic == W_LAST) && (ir == H_LAST);

    // Window-complete test for the pixel at (ir, ic); flush pixels keep counting past the last row.
    always_comb begin
        win_hit = 1'b0;
        if (PAD == 1)
            win_hit = (ir > P16) || ((ir == P16) && (ic >= P16));
        else
            win_hit = (ir >= K_LAST) && (ic >= K_LAST);
    end

    // Centre lags the newest pixel by P rows and P columns, borrowing a row when ic < P.
    always_comb begin
        cen_col = ic - P16;
        cen_row = ir - P16;
        if (ic < P16) begin
            cen_col = ic + W_MINUS_P;
            cen_row = ir - P16 - 16'd1;
        end
    end

    // Frame FSM: input raster counters, flush length and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            ic         <= '0;
            ir         <= '0;
            fcnt       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                RUN: begin
                    if (accept) begin
                        if (last_pix && USE_FLUSH) begin
                            state <= FLUSH;
                            fcnt  <= '0;
                            ic    <= '0;
                            ir    <= ir + 16'd1;
                        end else if (last_pix) begin
                            frame_done <= 1'b1;
                            ic         <= '0;
                            ir         <= '0;
                        end else if (ic == W_LAST) begin
                            ic <= '0;
                            ir <= ir + 16'd1;
                        end else begin
                            ic <= ic + 16'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt == FLUSH_LAST) begin
                        state      <= RUN;
                        frame_done <= 1'b1;
                        fcnt       <= '0;
                        ic         <= '0;
                        ir         <= '0;
                    end else begin
                        fcnt <= fcnt + 16'd1;
                        if (ic == W_LAST) begin
                            ic <= '0;
                            ir <= ir + 16'd1;
                        end else begin
                            ic <= ic + 16'd1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Window strobe and centre coordinates; coordinates hold between windows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_vld <= 1'b0;
            ccol    <= '0;
            crow    <= '0;
        end else begin
            win_vld <= pix_evt && win_hit;
            if (pix_evt && win_hit) begin
                ccol <= cen_col;
                crow <= cen_row;
            end
        end
    end

    // Conv and bias valid shift registers; they never stall so gaps are preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_pipe <= '0;
            bias_pipe <= '0;
        end else begin
            conv_pipe[0] <= win_vld;
            for (int k = 1; k < CONV_LAT; k++) conv_pipe[k] <= conv_pipe[k-1];
            bias_pipe[0] <= conv_pipe[CONV_LAT-1];
            for (int k = 1; k < BIAS_LAT; k++) bias_pipe[k] <= bias_pipe[k-1];
        end
    end

    // Output raster counters and pooled strobe; odd trailing column/row never pairs up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oc      <= '0;
            orow    <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= (POOL_EN != 0) ? (bias_pipe[BIAS_LAT-1] && oc[0] && orow[0])
                                      : bias_pipe[BIAS_LAT-1];
            if (bias_pipe[BIAS_LAT-1]) begin
                if (oc == OW_LAST) begin
                    oc   <= '0;
                    orow <= (orow == OH_LAST) ? 16'd0 : orow + 16'd1;
                end else begin
                    oc <= oc + 16'd1;
                end
            end
        end
    end

    assign cl.busy                = (state == FLUSH);
    assign cl.padding_valid       = (state == FLUSH);
    assign cl.counter_col         = ccol;
    assign cl.counter_row         = crow;
    assign cl.valid_window        = win_vld;
    assign cl.valid_pipeline_conv = conv_pipe;
    assign cl.valid_in_bias       = conv_pipe[CONV_LAT-1];
    assign cl.valid_pipeline_bias = bias_pipe;
    assign cl.valid_in_pool       = bias_pipe[BIAS_LAT-1];
    assign cl.valid_pool_h        = (POOL_EN != 0) && bias_pipe[BIAS_LAT-1] && oc[0];
    assign cl.valid_out           = out_vld;
    assign cl.frame_done          = frame_done;
endmodule
